dp_enqueue_ctrl: RTL and testbench
==================================

# dp_enqueue_ctrl

Write-side controller for the double-pumped BRAM output queues. It runs on `clock_2x`, samples up to two enqueue requests per 1x cycle (two lanes), and serializes them onto the single BRAM write port across the two halves of the 1x cycle. It owns per-queue write pointers and occupancy counts, and publishes `full` flags to the enqueuing logic. Occupancy is decremented from the already-gated dequeue pulses produced on the read side.

## Interface
- `NQ`, 4: number of queues; must be a power of 2.
- `LOG_NQ`, 2: log2(NQ).
- `DEPTH`, 16: entries per queue; must be a power of 2, ≥ 4.
- `LOG_DEPTH`, 4: log2(DEPTH).
- `W`, 32: data width.

Ports:
- `clock_2x`  in  1  double-rate clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `phase`  out  1  1x-cycle half indicator; 0 = first half.
- `lane0_valid`, `lane1_valid`  in  1  enqueue request per lane; held stable for the whole 1x cycle.
- `lane0_qid`, `lane1_qid`  in  LOG_NQ  target queue.
- `lane0_data`, `lane1_data`  in  W  payload.
- `dequeue`  in  NQ  one-`clock_2x`-cycle pulses, one per entry removed.
- `full`  out  NQ  per-queue "cannot accept two more".
- `ram_we`  out  1  BRAM write enable.
- `ram_addr`  out  LOG_NQ+LOG_DEPTH  address {qid, wptr}.
- `ram_wdata`  out  W  write data.
- `overflow`, `underflow`  out  1  sticky error flags.

## Operation
- `phase` toggles every `clock_2x` edge.
- Sample edge: any edge where `phase` == 0 before the edge. Requests are accepted only there and ignored at `phase` == 1 edges.
- Acceptance at a sample edge, lane0 evaluated before lane1:
  - A lane is accepted iff valid and count[qid] + (lane0 accepted into the same qid) < DEPTH.
  - Dequeues at the same edge do not create room.
  - A rejected lane is dropped and sets `overflow`.
- Accepted lanes are latched with their slot address: wptr[qid], then wptr[qid]+1 if both lanes target the same queue, lane0 lower. wptr advances mod DEPTH.
- Count update per queue, every edge: count += accepts(0..2) − (`dequeue`[q] && count > 0). Simultaneous accept and dequeue are both applied. Count width is LOG_DEPTH+1.
- `dequeue`[q] with count == 0 is ignored and sets `underflow`.
- `full`[q] = registered (count[q] ≥ DEPTH−1). Senders must not target a full queue.
- Write issue:
  - Held lane0 is written on the edge after the sample.
  - Held lane1 is written on the edge after that (coincides with the next sample edge).
  - An unaccepted lane issues `ram_we` = 0.
- Reset, from any state:
  - `phase` = 0; all counts and wptrs = 0; `full` = 0.
  - `ram_we` = 0; `ram_addr` and `ram_wdata` = 0.
  - `overflow` and `underflow` = 0.
  - Held, unwritten lanes are discarded.

## Timing
- Sample at edge E → lane0 BRAM write presented after E+1 and committed on E+2 → lane1 presented after E+2 and committed on E+3.
- Count reflects an accept from edge E+1 onward, before the data is written. The read side must not dequeue an entry earlier than 2 `clock_2x` cycles after its count increment.
- `full` lags count by one edge.
- Sustained throughput: 2 writes per 1x cycle; `ram_we` can be high on every `clock_2x` cycle.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- `DP_ENQ_ERR_FLAGS_EN`:
  - Defined: overflow/underflow detection and the sticky `overflow`/`underflow` registers are built.
  - Undefined: both ports are tied to 0 and the sticky registers are not built. Drop-on-full and ignore-on-empty behaviour is unchanged.

## Structure
- Shared header `dp_queue_defs.vh`: address-packing macro {qid, wptr} and phase encoding (0 = first half). The dequeue side includes the same header.
- One sub-module, `dp_queue_occ`, instantiated NQ times. Per queue it holds:
  - count and wptr;
  - accept-by-1/2 and dequeue inputs;
  - `full` and underflow-event outputs.
- Lane arbitration and the write mux stay in the top module.

## Test plan
- Reset, lane0 → q1, data 0xA5A5A5A5:
  - Sample edge E: count[1] = 1 at E+1.
  - `ram_we` = 1 with `ram_addr` = {1,0} and that data, presented after E+1, committed on E+2; nothing written for lane1.
- Both lanes → q2, data 0x11 and 0x22: lane0 addr {2,0}, lane1 addr {2,1} on consecutive cycles; count[2] = 2.
- Fill q0 with 15 entries: `full`[0] rises one edge after count = 15. A further 2-lane request to q0 accepts lane0, drops lane1, sets `overflow`, and count = 16.
- q3 count = 3; lane0 → q3 accepted and `dequeue`[3] pulsed on the same edge: count stays 3. `dequeue`[0] with count[0] = 0 sets `underflow`; count stays 0.
- Wrap: 17 single writes to q1 with interleaved dequeues: the 17th writes addr {1,0}.
- Reset asserted between sample and lane1 issue: `ram_we` = 0 on the next edge, all counts 0, `phase` = 0.

Source files
------------

// File: rtl/dp_enqueue_ctrl_pkg.sv
// Default geometry for the double-pumped output queues and small shared helpers.
package dp_enqueue_ctrl_pkg;

  localparam int DEF_NQ        = 4;
  localparam int DEF_LOG_NQ    = 2;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_LOG_DEPTH = 4;
  localparam int DEF_W         = 32;

  // Number of lanes (0..2) landing in one queue at a sample edge.
  function automatic logic [1:0] lane_hits(input logic hit0, input logic hit1);
    return {1'b0, hit0} + {1'b0, hit1};
  endfunction

endpackage

// File: rtl/dp_queue_defs.vh
// Shared by the enqueue and dequeue sides: BRAM slot address packing and phase encoding.
`ifndef DP_QUEUE_DEFS_VH
`define DP_QUEUE_DEFS_VH

`define DP_QADDR(qid, wptr) {(qid), (wptr)}
`define DP_PHASE_FIRST  1'b0
`define DP_PHASE_SECOND 1'b1

`endif

// File: rtl/dp_queue_occ.sv
// Per-queue occupancy and write pointer; count updates on the edge of an accept/dequeue,
// full is registered one edge behind count, dequeue on an empty queue is ignored and flagged.
module dp_queue_occ
  import dp_enqueue_ctrl_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LOG_DEPTH = DEF_LOG_DEPTH
) (
  input  logic                 clock_2x,
  input  logic                 reset,
  input  logic [1:0]           accept,
  input  logic                 dequeue,
  output logic [LOG_DEPTH:0]   count,
  output logic [LOG_DEPTH-1:0] wptr,
  output logic                 full,
  output logic                 underflow_evt
);

  localparam int FULL_AT = DEPTH - 1;

  logic deq_ok;

  assign deq_ok        = dequeue && (count != '0);
  assign underflow_evt = dequeue && (count == '0);

  always_ff @(posedge clock_2x) begin
    if (reset) begin
      count <= '0;
      wptr  <= '0;
      full  <= 1'b0;
    end else begin
      count <= count + {{(LOG_DEPTH-1){1'b0}}, accept} - {{LOG_DEPTH{1'b0}}, deq_ok};
      wptr  <= wptr + {{(LOG_DEPTH-2){1'b0}}, accept};
      // "Cannot take two more" is judged on the count before this edge's update.
      full  <= (count >= FULL_AT[LOG_DEPTH:0]);
    end
  end

endmodule

// File: rtl/dp_enqueue_ctrl.sv
// Two-lane enqueue serializer onto one BRAM write port; lane0 written 1 edge, lane1 2 edges after sample.
// No backpressure: requests over capacity are dropped; sticky error flags built only with DP_ENQ_ERR_FLAGS_EN.
`include "dp_queue_defs.vh"

module dp_enqueue_ctrl
  import dp_enqueue_ctrl_pkg::*;
#(
  parameter int NQ        = DEF_NQ,
  parameter int LOG_NQ    = DEF_LOG_NQ,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LOG_DEPTH = DEF_LOG_DEPTH,
  parameter int W         = DEF_W
) (
  input  logic                        clock_2x,
  input  logic                        reset,
  output logic                        phase,
  input  logic                        lane0_valid,
  input  logic                        lane1_valid,
  input  logic [LOG_NQ-1:0]           lane0_qid,
  input  logic [LOG_NQ-1:0]           lane1_qid,
  input  logic [W-1:0]                lane0_data,
  input  logic [W-1:0]                lane1_data,
  input  logic [NQ-1:0]               dequeue,
  output logic [NQ-1:0]               full,
  output logic                        ram_we,
  output logic [LOG_NQ+LOG_DEPTH-1:0] ram_addr,
  output logic [W-1:0]                ram_wdata,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int CW = LOG_DEPTH + 1;
  localparam int AW = LOG_NQ + LOG_DEPTH;

  logic [CW-1:0]        count [NQ];
  logic [LOG_DEPTH-1:0] wptr  [NQ];
  logic [NQ-1:0]        uf_evt;
  logic [NQ-1:0]        hit0, hit1;
  logic                 sample, same_q, acc0, acc1;
  logic [CW:0]          lane1_occ;
  logic [AW-1:0]        slot0, slot1;

  logic          h0_vld, h1_vld;
  logic [AW-1:0] h0_addr, h1_addr;
  logic [W-1:0]  h0_data, h1_data;

  always_comb begin
    sample    = (phase == `DP_PHASE_FIRST);
    same_q    = (lane0_qid == lane1_qid);
    acc0      = sample && lane0_valid && (count[lane0_qid] < DEPTH[CW-1:0]);
    // lane1 sees lane0's slot as taken; same-edge dequeues never make room.
    lane1_occ = {1'b0, count[lane1_qid]} + {{CW{1'b0}}, acc0 && same_q};
    acc1      = sample && lane1_valid && (lane1_occ < DEPTH[CW:0]);
    hit0            = '0;
    hit1            = '0;
    hit0[lane0_qid] = acc0;
    hit1[lane1_qid] = acc1;
    slot0 = `DP_QADDR(lane0_qid, wptr[lane0_qid]);
    slot1 = `DP_QADDR(lane1_qid, wptr[lane1_qid] + {{(LOG_DEPTH-1){1'b0}}, acc0 && same_q});
  end

  for (genvar q = 0; q < NQ; q++) begin : g_occ
    dp_queue_occ #(
      .DEPTH     (DEPTH),
      .LOG_DEPTH (LOG_DEPTH)
    ) u_occ (
      .clock_2x      (clock_2x),
      .reset         (reset),
      .accept        (lane_hits(hit0[q], hit1[q])),
      .dequeue       (dequeue[q]),
      .count         (count[q]),
      .wptr          (wptr[q]),
      .full          (full[q]),
      .underflow_evt (uf_evt[q])
    );
  end

  always_ff @(posedge clock_2x) begin
    if (reset) begin
      phase     <= `DP_PHASE_FIRST;
      h0_vld    <= 1'b0;
      h1_vld    <= 1'b0;
      h0_addr   <= '0;
      h1_addr   <= '0;
      h0_data   <= '0;
      h1_data   <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      phase <= ~phase;
      if (sample) begin
        h0_vld    <= acc0;
        h0_addr   <= slot0;
        h0_data   <= lane0_data;
        h1_vld    <= acc1;
        h1_addr   <= slot1;
        h1_data   <= lane1_data;
        // Previous cycle's lane1 drains on the same edge the next pair is captured.
        ram_we    <= h1_vld;
        ram_addr  <= h1_addr;
        ram_wdata <= h1_data;
      end else begin
        ram_we    <= h0_vld;
        ram_addr  <= h0_addr;
        ram_wdata <= h0_data;
      end
    end
  end

`ifdef DP_ENQ_ERR_FLAGS_EN
  always_ff @(posedge clock_2x) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (sample && ((lane0_valid && !acc0) || (lane1_valid && !acc1)))
        overflow <= 1'b1;
      if (|uf_evt)
        underflow <= 1'b1;
    end
  end
`else
  logic [NQ-1:0] uf_evt_unused;
  assign uf_evt_unused = uf_evt;
  assign overflow      = 1'b0;
  assign underflow     = 1'b0;
`endif

endmodule

// File: tb/tb_dp_enqueue_ctrl.sv
// Bench for dp_enqueue_ctrl: timeline model of accepted writes and occupancy, plus literal pins.
module tb_dp_enqueue_ctrl;

  localparam int NQ    = 4;
  localparam int DEPTH = 16;
`ifdef DP_ENQ_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock_2x;
  logic        reset;
  logic        phase;
  logic        lane0_valid, lane1_valid;
  logic [1:0]  lane0_qid, lane1_qid;
  logic [31:0] lane0_data, lane1_data;
  logic [3:0]  dequeue;
  logic [3:0]  full;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        overflow, underflow;

  dp_enqueue_ctrl dut (
    .clock_2x    (clock_2x),
    .reset       (reset),
    .phase       (phase),
    .lane0_valid (lane0_valid),
    .lane1_valid (lane1_valid),
    .lane0_qid   (lane0_qid),
    .lane1_qid   (lane1_qid),
    .lane0_data  (lane0_data),
    .lane1_data  (lane1_data),
    .dequeue     (dequeue),
    .full        (full),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  logic [4:0] dut_cnt [4];
  assign dut_cnt[0] = dut.g_occ[0].u_occ.count;
  assign dut_cnt[1] = dut.g_occ[1].u_occ.count;
  assign dut_cnt[2] = dut.g_occ[2].u_occ.count;
  assign dut_cnt[3] = dut.g_occ[3].u_occ.count;

  initial begin
    clock_2x = 1'b0;
    forever #5 clock_2x = ~clock_2x;
  end

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: a list of scheduled writes keyed by absolute edge number, plus integer counts.
  typedef struct {
    int          edge_no;
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sched[$];
  int          edge_no = 0;
  int          m_cnt [NQ];
  int          m_wp  [NQ];
  logic [3:0]  m_full;
  logic        m_phase, m_ovf, m_unf, m_we;
  logic [5:0]  m_addr;
  logic [31:0] m_data;

  always @(posedge clock_2x) begin
    int q;
    int pre [NQ];
    if (reset) begin
      sched.delete();
      for (int i = 0; i < NQ; i++) begin
        m_cnt[i] = 0;
        m_wp[i]  = 0;
      end
      m_full = '0; m_phase = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_we = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      edge_no++;
      for (int i = 0; i < NQ; i++) begin
        pre[i]    = m_cnt[i];
        m_full[i] = (pre[i] >= DEPTH - 1);
      end
      if (m_phase == 1'b0) begin
        if (lane0_valid) begin
          q = lane0_qid;
          if (m_cnt[q] < DEPTH) begin
            sched.push_back('{edge_no + 1, 6'(q * DEPTH + m_wp[q]), lane0_data});
            m_wp[q] = (m_wp[q] + 1) % DEPTH;
            m_cnt[q]++;
          end else m_ovf = 1'b1;
        end
        if (lane1_valid) begin
          q = lane1_qid;
          if (m_cnt[q] < DEPTH) begin
            sched.push_back('{edge_no + 2, 6'(q * DEPTH + m_wp[q]), lane1_data});
            m_wp[q] = (m_wp[q] + 1) % DEPTH;
            m_cnt[q]++;
          end else m_ovf = 1'b1;
        end
      end
      for (int i = 0; i < NQ; i++)
        if (dequeue[i]) begin
          if (pre[i] > 0) m_cnt[i]--;
          else m_unf = 1'b1;
        end
      m_phase = ~m_phase;
      m_we = 1'b0;
      for (int i = 0; i < sched.size(); i++)
        if (sched[i].edge_no == edge_no) begin
          m_we = 1'b1; m_addr = sched[i].addr; m_data = sched[i].data;
        end
      while (sched.size() > 0 && sched[0].edge_no <= edge_no) sched.delete(0);
    end
  end

  always @(negedge clock_2x) begin
    if (chk_en) begin
      check("phase", phase, m_phase);
      check("full", full, m_full);
      for (int i = 0; i < NQ; i++) check($sformatf("count%0d", i), dut_cnt[i], m_cnt[i]);
      check("overflow", overflow, ERR_EN & m_ovf);
      check("underflow", underflow, ERR_EN & m_unf);
      check("ram_we", ram_we, m_we);
      if (m_we) begin
        check("ram_addr", ram_addr, m_addr);
        check("ram_wdata", ram_wdata, m_data);
      end
    end
  end

  task automatic align();
    if (m_phase != 1'b0) @(negedge clock_2x);
  endtask

  task automatic issue(input bit v0, input int q0, input logic [31:0] d0,
                       input bit v1, input int q1, input logic [31:0] d1);
    align();
    lane0_valid = v0; lane0_qid = q0[1:0]; lane0_data = d0;
    lane1_valid = v1; lane1_qid = q1[1:0]; lane1_data = d1;
  endtask

  task automatic clear();
    lane0_valid = 1'b0; lane1_valid = 1'b0;
  endtask

  task automatic send(input bit v0, input int q0, input logic [31:0] d0,
                      input bit v1, input int q1, input logic [31:0] d1);
    issue(v0, q0, d0, v1, q1, d1);
    @(negedge clock_2x);
    @(negedge clock_2x);
    clear();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock_2x);
    @(negedge clock_2x);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; dequeue = '0;
    lane0_valid = 1'b0; lane1_valid = 1'b0;
    lane0_qid = '0; lane1_qid = '0; lane0_data = '0; lane1_data = '0;
    @(posedge clock_2x);
    @(negedge clock_2x);
    chk_en = 1'b1;
    @(negedge clock_2x);
    reset = 1'b0;
    check("rst_phase", phase, 0);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);

    // Single lane0 write to q1.
    issue(1, 1, 32'hA5A5A5A5, 0, 0, 0);
    @(negedge clock_2x);
    check("t1_count1", dut_cnt[1], 1);
    check("t1_we_before", ram_we, 0);
    @(negedge clock_2x);
    check("t1_we", ram_we, 1);
    check("t1_addr", ram_addr, 6'h10);
    check("t1_data", ram_wdata, 32'hA5A5A5A5);
    clear();
    @(negedge clock_2x);
    check("t1_no_lane1", ram_we, 0);

    // Both lanes to q2.
    issue(1, 2, 32'h11, 1, 2, 32'h22);
    @(negedge clock_2x);
    @(negedge clock_2x);
    check("t2_addr0", ram_addr, 6'h20);
    check("t2_data0", ram_wdata, 32'h11);
    clear();
    @(negedge clock_2x);
    check("t2_we1", ram_we, 1);
    check("t2_addr1", ram_addr, 6'h21);
    check("t2_data1", ram_wdata, 32'h22);
    check("t2_count2", dut_cnt[2], 2);

    // Dequeue on an empty queue.
    dequeue = 4'b0001;
    @(negedge clock_2x);
    dequeue = '0;
    check("t3_count0", dut_cnt[0], 0);
    check("t3_underflow", underflow, ERR_EN);

    // Accept and dequeue on the same edge cancel out.
    send(1, 3, 32'h31, 1, 3, 32'h32);
    send(1, 3, 32'h33, 0, 0, 0);
    check("t4_count3_pre", dut_cnt[3], 3);
    issue(1, 3, 32'h34, 0, 0, 0);
    dequeue = 4'b1000;
    @(negedge clock_2x);
    dequeue = '0;
    check("t4_count3", dut_cnt[3], 3);
    @(negedge clock_2x);
    clear();

    // Fill q0 to 15, watch full, then overflow with a 2-lane request.
    for (int i = 0; i < 7; i++) send(1, 0, 32'h100 + i, 1, 0, 32'h200 + i);
    issue(1, 0, 32'hF0, 0, 0, 0);
    @(negedge clock_2x);
    check("t5_count15", dut_cnt[0], 15);
    check("t5_full_lag", full[0], 0);
    @(negedge clock_2x);
    check("t5_full", full[0], 1);
    clear();
    issue(1, 0, 32'hAB, 1, 0, 32'hCD);
    @(negedge clock_2x);
    check("t5_count16", dut_cnt[0], 16);
    check("t5_overflow", overflow, ERR_EN);
    @(negedge clock_2x);
    check("t5_we", ram_we, 1);
    check("t5_addr", ram_addr, 6'h0F);
    check("t5_data", ram_wdata, 32'hAB);
    clear();
    @(negedge clock_2x);
    check("t5_dropped", ram_we, 0);

    // Write pointer wrap on q1 with a dequeue after every write.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      issue(1, 1, 32'h5000 + i, 0, 0, 0);
      @(negedge clock_2x);
      @(negedge clock_2x);
      if (i == 15) check("t6_addr15", ram_addr, 6'h1F);
      if (i == 16) begin
        check("t6_wrap_we", ram_we, 1);
        check("t6_wrap_addr", ram_addr, 6'h10);
      end
      clear();
      dequeue = 4'b0010;
      @(negedge clock_2x);
      dequeue = '0;
    end
    check("t6_count1", dut_cnt[1], 0);

    // Reset between the lane0 and lane1 writes drops lane1.
    issue(1, 2, 32'h77, 1, 2, 32'h88);
    @(negedge clock_2x);
    @(negedge clock_2x);
    reset = 1'b1;
    @(negedge clock_2x);
    clear();
    check("t7_we", ram_we, 0);
    check("t7_count2", dut_cnt[2], 0);
    check("t7_phase", phase, 0);
    reset = 1'b0;
    repeat (4) @(negedge clock_2x);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
